// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared writeback entry type, datapath widths and FIFO depth check
package core_pkg;

  localparam int XLEN  = 32;
  localparam int RF_AW = 4;

  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  wdata;
    logic             wb;
    logic [XLEN-1:0]  dnpc;
    logic             jump;
    logic             branch;
  } wb_entry_t;

  function automatic bit is_pow2(input int d);
    return (d >= 1) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/wbu_buf_if.sv
// rtl/wbu_buf_if.sv - LSU/IFU/register-file bundle of wbu_buf; WBU_FWD_EN adds the forwarding port
interface wbu_buf_if
  import core_pkg::*;
#(
  parameter int RET_W = 64
);

  logic             in_valid;
  logic             in_ready;
  logic [RF_AW-1:0] in_rd;
  logic [XLEN-1:0]  in_wdata;
  logic             in_wb;
  logic [XLEN-1:0]  in_dnpc;
  logic             in_jump;
  logic             in_branch;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_dnpc;
  logic             out_jump;
  logic             out_branch;
  logic             flush;
  logic             rf_we;
  logic [RF_AW-1:0] rf_rd;
  logic [XLEN-1:0]  rf_wdata;
  logic [RET_W-1:0] retired;
`ifdef WBU_FWD_EN
  logic [RF_AW-1:0] fwd_rs;
  logic             fwd_hit;
  logic [XLEN-1:0]  fwd_data;
`endif

  modport slave (
    input  in_valid, in_rd, in_wdata, in_wb, in_dnpc, in_jump, in_branch,
    input  out_ready, flush,
    output in_ready, out_valid, out_dnpc, out_jump, out_branch,
    output rf_we, rf_rd, rf_wdata, retired
`ifdef WBU_FWD_EN
    , input fwd_rs, output fwd_hit, fwd_data
`endif
  );

  modport master (
    output in_valid, in_rd, in_wdata, in_wb, in_dnpc, in_jump, in_branch,
    output out_ready, flush,
    input  in_ready, out_valid, out_dnpc, out_jump, out_branch,
    input  rf_we, rf_rd, rf_wdata, retired
`ifdef WBU_FWD_EN
    , output fwd_rs, input fwd_hit, fwd_data
`endif
  );

endinterface

// File: rtl/wbu_fifo.sv
// rtl/wbu_fifo.sv - storage FIFO of wb_entry_t with push/pop/flush; WBU_FWD_EN adds the buffered-entry search
module wbu_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_i,
  input  wb_entry_t                    push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output wb_entry_t                    head_o
`ifdef WBU_FWD_EN
  ,
  input  logic [RF_AW-1:0]             fwd_rs_i,
  output logic                         fwd_hit_o,
  output logic [XLEN-1:0]              fwd_data_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("wbu_fifo: DEPTH must be a power of two");
  end

  wb_entry_t        mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_idx, wr_idx;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_idx];

  // Flush wins over both sides; the guards here keep the FIFO safe whatever the caller does.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;

  if (DEPTH == 1) begin : g_single
    assign rd_idx = '0;
    assign wr_idx = '0;
  end else begin : g_ring
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
    assign rd_idx = rd_ptr_q;
    assign wr_idx = wr_ptr_q;
  end

  always_comb begin
    count_d = count_q;
    if (flush_i)                count_d = '0;
    else if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) mem_q[wr_idx] <= push_data_i;
    end
  end

`ifdef WBU_FWD_EN
  // Walk oldest to youngest so the last match, i.e. the youngest, wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_idx + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && mem_q[idx].wb &&
          (mem_q[idx].rd == fwd_rs_i) && (fwd_rs_i != '0)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = mem_q[idx].wdata;
      end
    end
  end
`endif

endmodule

// File: rtl/wbu_buf.sv
// rtl/wbu_buf.sv - writeback buffer: entry FIFO, commit register, retired counter; WBU_FWD_EN adds forwarding
module wbu_buf
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RET_W = 64
) (
  input logic      clock,
  input logic      reset,
  wbu_buf_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        push_entry, head;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             in_ready, out_valid, push, pop;

  logic             rf_we_q, rf_we_d;
  logic [RF_AW-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic [RET_W-1:0] retired_q, retired_d;

`ifdef WBU_FWD_EN
  logic             buf_hit;
  logic [XLEN-1:0]  buf_data;
`endif

  always_comb begin
    push_entry        = '0;
    push_entry.rd     = bus.in_rd;
    push_entry.wdata  = bus.in_wdata;
    push_entry.wb     = bus.in_wb;
    push_entry.dnpc   = bus.in_dnpc;
    push_entry.jump   = bus.in_jump;
    push_entry.branch = bus.in_branch;
  end

  // in_ready looks only at stored occupancy so IFU back-pressure never reaches LSU in the same cycle.
  assign in_ready  = reset && !fifo_full && !bus.flush;
  assign out_valid = (fifo_count != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready && !bus.flush;

  wbu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (bus.flush),
    .full_o      (fifo_full),
    .count_o     (fifo_count),
    .head_o      (head)
`ifdef WBU_FWD_EN
    ,
    .fwd_rs_i    (bus.fwd_rs),
    .fwd_hit_o   (buf_hit),
    .fwd_data_o  (buf_data)
`endif
  );

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_dnpc   = out_valid ? head.dnpc : '0;
  assign bus.out_jump   = out_valid && head.jump;
  assign bus.out_branch = out_valid && head.branch;

  // x0 writes are dropped here rather than at the register file.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = '0;
    rf_wdata_d = '0;
    retired_d  = retired_q;
    if (pop) begin
      retired_d = retired_q + RET_W'(1);
      if (head.wb && (head.rd != '0)) begin
        rf_we_d    = 1'b1;
        rf_rd_d    = head.rd;
        rf_wdata_d = head.wdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      retired_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      retired_q  <= retired_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_rd    = rf_rd_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.retired  = retired_q;

`ifdef WBU_FWD_EN
  // Buffered entries are younger than the one already in the write stage.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    if (buf_hit) begin
      bus.fwd_hit  = 1'b1;
      bus.fwd_data = buf_data;
    end else if (rf_we_q && (rf_rd_q == bus.fwd_rs) && (bus.fwd_rs != '0)) begin
      bus.fwd_hit  = 1'b1;
      bus.fwd_data = rf_wdata_q;
    end
  end
`endif

endmodule

// File: tb/tb_wbu_buf.sv
// tb/tb_wbu_buf.sv - self-checking bench for wbu_buf (DEPTH=2); WBU_FWD_EN enables the forwarding checks
module tb_wbu_buf;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  wbu_buf_if #(.RET_W(64)) bus ();

  wbu_buf #(.DEPTH(DEPTH), .RET_W(64)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        iv;
    logic [3:0]  rd;
    logic [31:0] wd;
    logic        wb;
    logic [31:0] dn;
    logic        jp, br, ordy, fl;
    logic        e_irdy, e_ov;
    logic [31:0] e_dn;
    logic        e_jp, e_br, e_we;
    logic [3:0]  e_rd;
    logic [31:0] e_wd;
    int          e_ret;
  } vec_t;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] wd;
    logic        wb;
    logic [31:0] dn;
    logic        jp, br;
  } ent_t;

  vec_t tbl[$];

  task automatic add(input logic iv, input logic [3:0] rd, input logic [31:0] wd, input logic wb,
                     input logic [31:0] dn, input logic jp, input logic br, input logic ordy,
                     input logic fl, input logic e_irdy, input logic e_ov, input logic [31:0] e_dn,
                     input logic e_jp, input logic e_br, input logic e_we, input logic [3:0] e_rd,
                     input logic [31:0] e_wd, input int e_ret);
    vec_t v;
    v.iv = iv; v.rd = rd; v.wd = wd; v.wb = wb; v.dn = dn; v.jp = jp; v.br = br;
    v.ordy = ordy; v.fl = fl; v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_dn = e_dn;
    v.e_jp = e_jp; v.e_br = e_br; v.e_we = e_we; v.e_rd = e_rd; v.e_wd = e_wd; v.e_ret = e_ret;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] rd, input logic [31:0] wd, input logic wb,
                       input logic [31:0] dn, input logic jp, input logic br, input logic ordy,
                       input logic fl);
    bus.in_valid = iv; bus.in_rd = rd; bus.in_wdata = wd; bus.in_wb = wb; bus.in_dnpc = dn;
    bus.in_jump = jp; bus.in_branch = br; bus.out_ready = ordy; bus.flush = fl;
  endtask

  task automatic chk_all(input string tag, input logic irdy, input logic ov, input logic [31:0] dn,
                         input logic jp, input logic br, input logic we, input logic [3:0] rd,
                         input logic [31:0] wd, input logic [63:0] ret);
    chk({tag, ".in_ready"},   64'(bus.in_ready),   64'(irdy));
    chk({tag, ".out_valid"},  64'(bus.out_valid),  64'(ov));
    chk({tag, ".out_dnpc"},   64'(bus.out_dnpc),   64'(dn));
    chk({tag, ".out_jump"},   64'(bus.out_jump),   64'(jp));
    chk({tag, ".out_branch"}, 64'(bus.out_branch), 64'(br));
    chk({tag, ".rf_we"},      64'(bus.rf_we),      64'(we));
    chk({tag, ".rf_rd"},      64'(bus.rf_rd),      64'(rd));
    chk({tag, ".rf_wdata"},   64'(bus.rf_wdata),   64'(wd));
    chk({tag, ".retired"},    bus.retired,         ret);
  endtask

  ent_t        q[$];
  logic        pend_v;
  ent_t        pend;
  longint unsigned ret_m;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef WBU_FWD_EN
    bus.fwd_rs = '0;
`endif
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    //  iv rd wdata         wb dnpc          jp br or fl | irdy ov dnpc          jp br we rd wdata         ret
    add(0, 0, 0,            0, 0,            0, 0, 1, 0,   1, 0, 0,            0, 0, 0, 0, 0,            0);
    add(1, 5, 32'hDEADBEEF, 1, 32'h80000004, 0, 0, 1, 0,   1, 0, 0,            0, 0, 0, 0, 0,            0);
    add(0, 0, 0,            0, 0,            0, 0, 1, 0,   1, 1, 32'h80000004, 0, 0, 0, 0, 0,            0);
    add(0, 0, 0,            0, 0,            0, 0, 1, 0,   1, 0, 0,            0, 0, 1, 5, 32'hDEADBEEF, 1);
    add(1, 0, 32'h1234,     1, 32'h80000008, 0, 0, 1, 0,   1, 0, 0,            0, 0, 0, 0, 0,            1);
    add(0, 0, 0,            0, 0,            0, 0, 1, 0,   1, 1, 32'h80000008, 0, 0, 0, 0, 0,            1);
    add(0, 0, 0,            0, 0,            0, 0, 1, 0,   1, 0, 0,            0, 0, 0, 0, 0,            2);
    add(1, 1, 32'h11,       1, 32'h100,      1, 0, 0, 0,   1, 0, 0,            0, 0, 0, 0, 0,            2);
    add(1, 2, 32'h22,       1, 32'h104,      0, 1, 0, 0,   1, 1, 32'h100,      1, 0, 0, 0, 0,            2);
    add(1, 3, 32'h33,       1, 32'h108,      0, 0, 0, 0,   0, 1, 32'h100,      1, 0, 0, 0, 0,            2);
    add(1, 3, 32'h33,       1, 32'h108,      0, 0, 1, 0,   0, 1, 32'h100,      1, 0, 0, 0, 0,            2);
    add(1, 3, 32'h33,       1, 32'h108,      0, 0, 1, 0,   1, 1, 32'h104,      0, 1, 1, 1, 32'h11,       3);
    add(0, 0, 0,            0, 0,            0, 0, 1, 0,   1, 1, 32'h108,      0, 0, 1, 2, 32'h22,       4);
    add(0, 0, 0,            0, 0,            0, 0, 1, 0,   1, 0, 0,            0, 0, 1, 3, 32'h33,       5);
    add(0, 0, 0,            0, 0,            0, 0, 0, 0,   1, 0, 0,            0, 0, 0, 0, 0,            5);
    add(1, 4, 32'h44,       1, 32'h200,      0, 0, 0, 0,   1, 0, 0,            0, 0, 0, 0, 0,            5);
    add(1, 5, 32'h55,       1, 32'h204,      0, 0, 0, 0,   1, 1, 32'h200,      0, 0, 0, 0, 0,            5);
    add(1, 6, 32'h66,       1, 32'h208,      0, 0, 1, 1,   0, 1, 32'h200,      0, 0, 0, 0, 0,            5);
    add(0, 0, 0,            0, 0,            0, 0, 1, 0,   1, 0, 0,            0, 0, 0, 0, 0,            5);
    add(1, 7, 32'h77,       1, 32'h300,      0, 0, 0, 0,   1, 0, 0,            0, 0, 0, 0, 0,            5);
    add(0, 0, 0,            0, 0,            0, 0, 1, 0,   1, 1, 32'h300,      0, 0, 0, 0, 0,            5);
    add(1, 8, 32'h88,       1, 32'h304,      0, 0, 1, 1,   0, 0, 0,            0, 0, 1, 7, 32'h77,       6);
    add(0, 0, 0,            0, 0,            0, 0, 1, 0,   1, 0, 0,            0, 0, 0, 0, 0,            6);
    add(1, 9, 32'h99,       0, 32'h400,      0, 0, 1, 0,   1, 0, 0,            0, 0, 0, 0, 0,            6);
    add(0, 0, 0,            0, 0,            0, 0, 1, 0,   1, 1, 32'h400,      0, 0, 0, 0, 0,            6);
    add(0, 0, 0,            0, 0,            0, 0, 1, 0,   1, 0, 0,            0, 0, 0, 0, 0,            7);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1 drive(tbl[i].iv, tbl[i].rd, tbl[i].wd, tbl[i].wb, tbl[i].dn, tbl[i].jp, tbl[i].br,
               tbl[i].ordy, tbl[i].fl);
      @(negedge clk);
      chk_all($sformatf("row%0d", i), tbl[i].e_irdy, tbl[i].e_ov, tbl[i].e_dn, tbl[i].e_jp,
              tbl[i].e_br, tbl[i].e_we, tbl[i].e_rd, tbl[i].e_wd, 64'(tbl[i].e_ret));
    end

`ifdef WBU_FWD_EN
    @(posedge clk); #1 drive(1, 3, 32'hA, 1, 32'h500, 0, 0, 0, 0);
    @(posedge clk); #1 drive(1, 3, 32'hB, 1, 32'h504, 0, 0, 0, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0); bus.fwd_rs = 4'd3;
    @(negedge clk);
    chk("fwd.rs3.hit", 64'(bus.fwd_hit), 64'd1);
    chk("fwd.rs3.data", 64'(bus.fwd_data), 64'hB);
    bus.fwd_rs = 4'd0; #1;
    chk("fwd.rs0.hit", 64'(bus.fwd_hit), 64'd0);
    chk("fwd.rs0.data", 64'(bus.fwd_data), 64'd0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    // Reset while a commit is pending and one entry is still buffered.
    @(posedge clk); #1 drive(1, 9, 32'h99, 1, 32'h600, 0, 0, 0, 0);
    @(posedge clk); #1 drive(1, 10, 32'hAA, 1, 32'h604, 0, 0, 0, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst.pre.rf_we", 64'(bus.rf_we), 64'd1);
    chk("rst.pre.out_dnpc", 64'(bus.out_dnpc), 64'h604);
    #1 rst_n = 1'b0;
    #1 chk_all("rst.mid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_all("rst.post", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    q.delete();
    pend_v = 1'b0;
    pend = '{default: '0};
    ret_m = 0;
    for (int c = 0; c < 2000; c++) begin
      ent_t e;
      ent_t h;
      logic fl, ordy, e_irdy, e_ov, do_push, do_pop;
      e.rd = 4'($urandom_range(0, 15));
      e.wd = $urandom;
      e.wb = ($urandom_range(0, 3) != 0);
      e.dn = $urandom;
      e.jp = 1'($urandom);
      e.br = 1'($urandom);
      fl   = ($urandom_range(0, 15) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1 drive(($urandom_range(0, 3) != 0), e.rd, e.wd, e.wb, e.dn, e.jp, e.br, ordy, fl);
`ifdef WBU_FWD_EN
      bus.fwd_rs = 4'($urandom_range(0, 15));
`endif
      @(negedge clk);
      e_irdy = (q.size() < DEPTH) && !fl;
      e_ov   = (q.size() != 0);
      h      = e_ov ? q[0] : '{default: '0};
      chk_all($sformatf("rnd%0d", c), e_irdy, e_ov, h.dn, h.jp, h.br, pend_v,
              pend_v ? pend.rd : 4'd0, pend_v ? pend.wd : 32'd0, ret_m);
`ifdef WBU_FWD_EN
      begin
        logic        fh;
        logic [31:0] fd;
        fh = 1'b0;
        fd = '0;
        if (bus.fwd_rs != 0) begin
          for (int k = q.size() - 1; k >= 0 && !fh; k--)
            if (q[k].wb && q[k].rd == bus.fwd_rs) begin fh = 1'b1; fd = q[k].wd; end
          if (!fh && pend_v && pend.rd == bus.fwd_rs) begin fh = 1'b1; fd = pend.wd; end
        end
        chk($sformatf("rnd%0d.fwd_hit", c), 64'(bus.fwd_hit), 64'(fh));
        chk($sformatf("rnd%0d.fwd_data", c), 64'(bus.fwd_data), 64'(fd));
      end
`endif
      do_push = bus.in_valid && e_irdy;
      do_pop  = e_ov && ordy && !fl;
      pend_v  = do_pop && h.wb && (h.rd != 0);
      pend    = h;
      if (do_pop) ret_m++;
      if (fl) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
